// File: rtl/luna_mem_pkg.sv
// Shared definitions for the port-A BRAM arbiter: default widths, requester ids
// and the default-width command record.
package luna_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  // Width of the starvation counter; covers STARVE_LIMIT up to 15.
  localparam int unsigned STARVE_W = 4;

  // Requester ids carried through the read-tag pipeline.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Command record at default widths (we, addr, wdata).
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Read-tag pipeline: shifts {valid, requester id} alongside the BRAM read so the
// returning data can be steered to whoever issued it.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the pipe)
//   valid_i/id_i : tag entering at the accepting edge
//   valid_o/id_o : tag aligned with valid bram_douta
// Depth must be at least 2 (1 command stage + READ_LATENCY >= 1).
module bram_rd_tag_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic id_i,
  output logic valid_o,
  output logic id_o
);

  logic [Depth-1:0] valid_q;
  logic [Depth-1:0] id_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= {valid_q[Depth-2:0], valid_i};
      id_q    <= {id_q[Depth-2:0], id_i};
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign id_o    = id_q[Depth-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Port-A owner for the shared BRAM: arbitrates CPU (primary) against DMA
// (secondary, with starvation guard), registers the winning command onto the
// BRAM pins and steers read data back to the issuing requester.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   cpu_*_i / cpu_*_o       : CPU request fields, grant, read-return
//   dma_*_i / dma_*_o       : DMA request fields, grant, read-return
//   bram_wea_o/addra_o/dina_o, bram_douta_i : BRAM port-A pins
// rst_i is expected to be released synchronously by the reset synchroniser.
module bram_port_arbiter
  import luna_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_W_DEF,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  input  logic                  dma_req_i,
  input  logic                  dma_we_i,
  input  logic [ADDR_WIDTH-1:0] dma_addr_i,
  input  logic [DATA_WIDTH-1:0] dma_wdata_i,
  output logic                  dma_gnt_o,
  output logic                  dma_rvalid_o,
  output logic [DATA_WIDTH-1:0] dma_rdata_o,
  output logic                  bram_wea_o,
  output logic [ADDR_WIDTH-1:0] bram_addra_o,
  output logic [DATA_WIDTH-1:0] bram_dina_o,
  input  logic [DATA_WIDTH-1:0] bram_douta_i
);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  wea_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] dina_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, dma_rdata_q;

  logic cpu_req, dma_req, dma_wins, accept, win_id;
  cmd_t win_cmd;
  logic tag_valid, tag_id;

  // Grant, starvation counter and winner select.
  always_comb begin
    // Nothing is accepted while reset is held.
    cpu_req  = cpu_req_i & ~rst_i;
    dma_req  = dma_req_i & ~rst_i;
    dma_wins = dma_req & (~cpu_req | (starve_q == StarveMax));
    dma_gnt_o = dma_wins;
    cpu_gnt_o = cpu_req & ~dma_wins;
    accept    = cpu_gnt_o | dma_gnt_o;
    win_id    = dma_wins ? REQ_DMA : REQ_CPU;
    win_cmd   = dma_wins ? cmd_t'{dma_we_i, dma_addr_i, dma_wdata_i}
                         : cmd_t'{cpu_we_i, cpu_addr_i, cpu_wdata_i};

    starve_d = starve_q;
    if (!dma_req || dma_gnt_o) begin
      starve_d = '0;
    end else if (cpu_gnt_o && starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q    <= '0;
      wea_q       <= 1'b0;
      addr_q      <= '0;
      dina_q      <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      // Write enable lasts exactly one cycle; address/data hold when idle.
      wea_q    <= accept & win_cmd.we;
      if (accept) begin
        addr_q <= win_cmd.addr;
        dina_q <= win_cmd.wdata;
      end
      cpu_rdata_q <= cpu_rdata_o;
      dma_rdata_q <= dma_rdata_o;
    end
  end

  bram_rd_tag_pipe #(
    .Depth (1 + READ_LATENCY)
  ) u_tag_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (accept & ~win_cmd.we),
    .id_i    (win_id),
    .valid_o (tag_valid),
    .id_o    (tag_id)
  );

  // Return mux: douta is passed straight through in the rvalid cycle, then held.
  always_comb begin
    cpu_rvalid_o = tag_valid & (tag_id == REQ_CPU);
    dma_rvalid_o = tag_valid & (tag_id == REQ_DMA);
    cpu_rdata_o  = cpu_rvalid_o ? bram_douta_i : cpu_rdata_q;
    dma_rdata_o  = dma_rvalid_o ? bram_douta_i : dma_rdata_q;
  end

  assign bram_wea_o   = wea_q;
  assign bram_addra_o = addr_q;
  assign bram_dina_o  = dina_q;

endmodule
